// File: rtl/bp_me_pkg.sv
// Shared types for the streaming-accelerator I/O scheduler: scheduler FSM
// states, the processor-config selector and width helpers.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_wide_cfg    = 2'd1
    } bp_params_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_send = 1'b1
    } bp_sacc_sched_state_e;

    localparam int sched_default_num_req_lp = 2;
    localparam int sched_req_idx_width_lp   = $clog2(sched_default_num_req_lp);

    function automatic int cce_mem_msg_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 64;
            default:          return 128;
        endcase
    endfunction

    // Index width for n requesters; a lone requester still needs one bit.
    function automatic int req_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO holding the requester tag of each issued command.
// Push while full and pop while empty are ignored.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   push_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   pop_i,
    output logic [width_p-1:0]     data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(els_p):0] count_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0]     mem_r [els_p];
    logic [ptr_w_lp-1:0]    wptr_r, rptr_r;
    logic [$clog2(els_p):0] count_r;
    logic                   do_push, do_pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_r == '0);
    assign full_o  = (count_r == ($clog2(els_p) + 1)'(els_p));
    assign count_o = count_r;
    assign data_o  = mem_r[rptr_r];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wptr_r <= ptr_inc(wptr_r);
            if (do_pop)  rptr_r <= ptr_inc(rptr_r);
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_sacc_io_sched.sv
// Round-robin scheduler for the tile's I/O command channel; responses are
// steered back to requesters through an in-order tag queue under a credit cap.
module bp_sacc_io_sched
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_default_cfg,
    parameter int num_req_p            = sched_default_num_req_lp,
    parameter int max_outstanding_p    = 4,
    localparam int msg_w_lp            = cce_mem_msg_width(bp_params_p),
    localparam int idx_w_lp            = req_idx_width(num_req_p),
    localparam int cnt_w_lp            = $clog2(max_outstanding_p) + 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0][msg_w_lp-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]               req_cmd_v_i,
    output logic [num_req_p-1:0]               req_cmd_ready_o,
    output logic [msg_w_lp-1:0]                req_resp_o,
    output logic [num_req_p-1:0]               req_resp_v_o,
    input  logic [num_req_p-1:0]               req_resp_yumi_i,
    output logic [msg_w_lp-1:0]                io_cmd_o,
    output logic                               io_cmd_v_o,
    input  logic                               io_cmd_yumi_i,
    input  logic [msg_w_lp-1:0]                io_resp_i,
    input  logic                               io_resp_v_i,
    output logic                               io_resp_ready_o,
    output logic [cnt_w_lp-1:0]                outstanding_o,
    output logic                               error_o,
    output logic                               state_o
);
    // Handshakes: a requester command transfers on v & ready; the link takes
    // io_cmd_o on io_cmd_v_o & io_cmd_yumi_i; a response transfers on
    // io_resp_v_i & io_resp_ready_o, which mirrors the head requester's yumi.

    bp_sacc_sched_state_e state_r, state_n;
    logic [idx_w_lp-1:0]  rr_ptr_r, grant, cand, head;
    logic                 grant_v, accept, resp_pop, err_set;
    logic                 fifo_full, fifo_empty;
    logic [msg_w_lp-1:0]  cmd_r;
    logic                 error_r;
    logic [num_req_p-1:0] head_mask;

    // Scan from the lowest rotated offset last so it wins: the first valid
    // requester after rr_ptr.
    always_comb begin
        grant_v = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            cand = idx_w_lp'((int'(rr_ptr_r) + 1 + i) % num_req_p);
            if (req_cmd_v_i[cand]) begin
                grant_v = 1'b1;
                grant   = cand;
            end
        end
    end

    always_comb begin
        req_cmd_ready_o = '0;
        if (state_r == e_idle && grant_v && !fifo_full) begin
            req_cmd_ready_o[grant] = 1'b1;
        end
    end

    assign accept = |(req_cmd_v_i & req_cmd_ready_o);

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle:  if (accept) state_n = e_send;
            e_send:  if (io_cmd_yumi_i) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    assign head_mask       = fifo_empty ? '0 : (num_req_p'(1) << head);
    assign req_resp_o      = io_resp_i;
    assign req_resp_v_o    = io_resp_v_i ? head_mask : '0;
    assign io_resp_ready_o = |(req_resp_yumi_i & head_mask);
    assign resp_pop        = io_resp_v_i & io_resp_ready_o;
    assign err_set         = (io_resp_v_i & fifo_empty) | (|(req_resp_yumi_i & ~head_mask));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= e_idle;
            rr_ptr_r <= idx_w_lp'(num_req_p - 1);
            cmd_r    <= '0;
            error_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                rr_ptr_r <= grant;
                cmd_r    <= req_cmd_i[grant];
            end
            if (err_set) error_r <= 1'b1;
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (idx_w_lp),
        .els_p   (max_outstanding_p)
    ) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (accept),
        .data_i    (grant),
        .pop_i     (resp_pop),
        .data_o    (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (outstanding_o)
    );

    assign io_cmd_v_o = (state_r == e_send);
    assign io_cmd_o   = cmd_r;
    assign error_o    = error_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_bp_sacc_io_sched.sv
// Scoreboard bench for bp_sacc_io_sched: round-robin, credits, steering,
// simultaneous push/pop, backpressure, reset and sticky errors.
module tb_bp_sacc_io_sched;
    import bp_me_pkg::*;

    localparam int NREQ = 2;
    localparam int MAXO = 4;
    localparam int W    = cce_mem_msg_width(e_bp_default_cfg);
    localparam int CW   = $clog2(MAXO) + 1;

    logic                     clk = 1'b0;
    logic                     reset_n_i;
    logic [NREQ-1:0][W-1:0]   req_cmd_i;
    logic [NREQ-1:0]          req_cmd_v_i;
    logic [NREQ-1:0]          req_cmd_ready_o;
    logic [W-1:0]             req_resp_o;
    logic [NREQ-1:0]          req_resp_v_o;
    logic [NREQ-1:0]          req_resp_yumi_i;
    logic [W-1:0]             io_cmd_o;
    logic                     io_cmd_v_o;
    logic                     io_cmd_yumi_i;
    logic [W-1:0]             io_resp_i;
    logic                     io_resp_v_i;
    logic                     io_resp_ready_o;
    logic [CW-1:0]            outstanding_o;
    logic                     error_o;
    logic                     state_o;

    bp_sacc_io_sched #(
        .bp_params_p       (e_bp_default_cfg),
        .num_req_p         (NREQ),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .req_cmd_i       (req_cmd_i),
        .req_cmd_v_i     (req_cmd_v_i),
        .req_cmd_ready_o (req_cmd_ready_o),
        .req_resp_o      (req_resp_o),
        .req_resp_v_o    (req_resp_v_o),
        .req_resp_yumi_i (req_resp_yumi_i),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_yumi_i   (io_cmd_yumi_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_ready_o (io_resp_ready_o),
        .outstanding_o   (outstanding_o),
        .error_o         (error_o),
        .state_o         (state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    logic [NREQ-1:0] exp_q[$];   // one-hot requester owed each response
    logic [W-1:0]    cmd_q[$];   // commands expected on the link
    int n_cmp = 0;
    int n_err = 0;
    int model_rr;
    int model_cnt;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int rr, input logic [NREQ-1:0] v);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(rr + i) % NREQ]) return (rr + i) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int g);
        return NREQ'(1) << g;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic rand_cmds();
        for (int r = 0; r < NREQ; r++) req_cmd_i[r] = rnd_word();
    endtask

    task automatic pop_cmd(output logic [W-1:0] c);
        c = (cmd_q.size() > 0) ? cmd_q.pop_front() : '0;
    endtask

    // Drivers
    task automatic accept_one(input logic [NREQ-1:0] v);
        int g;
        logic [W-1:0] c;
        @(negedge clk);
        rand_cmds();
        req_cmd_v_i = v;
        #1;
        g = pick(model_rr, v);
        check("accept_ready", req_cmd_ready_o, oh(g));
        model_rr = g;
        exp_q.push_back(oh(g));
        cmd_q.push_back(req_cmd_i[g]);
        model_cnt++;
        @(posedge clk);
        #1 req_cmd_v_i = '0;
        @(negedge clk);
        pop_cmd(c);
        check("send_valid", io_cmd_v_o, 1'b1);
        check("send_data", io_cmd_o, c);
        check("send_ready_low", req_cmd_ready_o, '0);
        check("count_after_accept", outstanding_o, model_cnt);
        io_cmd_yumi_i = 1'b1;
        @(posedge clk);
        #1 io_cmd_yumi_i = 1'b0;
    endtask

    task automatic respond_one();
        logic [W-1:0]    d;
        logic [NREQ-1:0] t;
        @(negedge clk);
        d = rnd_word();
        t = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        io_resp_v_i     = 1'b1;
        io_resp_i       = d;
        req_resp_yumi_i = t;
        #1;
        check("resp_steer", req_resp_v_o, t);
        check("resp_data", req_resp_o, d);
        check("resp_ready", io_resp_ready_o, 1'b1);
        model_cnt--;
        @(posedge clk);
        #1;
        io_resp_v_i     = 1'b0;
        req_resp_yumi_i = '0;
        check("resp_count", outstanding_o, model_cnt);
    endtask

    initial begin
        int g;
        logic [W-1:0]    c, d;
        logic [NREQ-1:0] t;

        reset_n_i       = 1'b0;
        req_cmd_i       = '0;
        req_cmd_v_i     = '0;
        req_resp_yumi_i = '0;
        io_cmd_yumi_i   = 1'b0;
        io_resp_i       = '0;
        io_resp_v_i     = 1'b0;
        model_rr        = NREQ - 1;
        model_cnt       = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_v", io_cmd_v_o, 1'b0);
        check("rst_count", outstanding_o, '0);
        check("rst_error", error_o, 1'b0);
        check("rst_state", state_o, e_idle);
        check("rst_cmd_data", io_cmd_o, '0);
        @(negedge clk) reset_n_i = 1'b1;

        // Round-robin with immediate yumi; no responses so credits fill up.
        @(negedge clk);
        rand_cmds();
        req_cmd_v_i   = '1;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                g = pick(model_rr, '1);
                check("rr_ready", req_cmd_ready_o, oh(g));
                check("rr_idle_cmd_v", io_cmd_v_o, 1'b0);
                model_rr = g;
                exp_q.push_back(oh(g));
                cmd_q.push_back(req_cmd_i[g]);
                model_cnt++;
            end else begin
                pop_cmd(c);
                check("rr_send_cmd_v", io_cmd_v_o, 1'b1);
                check("rr_send_data", io_cmd_o, c);
                check("rr_send_ready", req_cmd_ready_o, '0);
            end
            @(posedge clk);
            #1;
            if (i % 2 == 0) req_cmd_i[g] = rnd_word();
            @(negedge clk);
        end
        io_cmd_yumi_i = 1'b0;

        // Credit limit: ready stays low while the tag queue is full.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("credit_ready", req_cmd_ready_o, '0);
            check("credit_count", outstanding_o, MAXO);
            @(negedge clk);
        end
        req_cmd_v_i = '0;
        respond_one();
        accept_one('1);
        check("credit_refill", outstanding_o, MAXO);
        repeat (MAXO) respond_one();

        // Steering: issue r1, r0, r1.
        accept_one(2'b10);
        accept_one(2'b01);
        accept_one(2'b10);
        respond_one();

        // Accept and response in the same cycle at count 2.
        @(negedge clk);
        rand_cmds();
        req_cmd_v_i     = 2'b01;
        t               = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        d               = rnd_word();
        io_resp_v_i     = 1'b1;
        io_resp_i       = d;
        req_resp_yumi_i = t;
        #1;
        g = pick(model_rr, 2'b01);
        check("simul_ready", req_cmd_ready_o, oh(g));
        check("simul_steer", req_resp_v_o, t);
        check("simul_data", req_resp_o, d);
        model_rr = g;
        exp_q.push_back(oh(g));
        cmd_q.push_back(req_cmd_i[g]);
        @(posedge clk);
        #1;
        req_cmd_v_i     = '0;
        io_resp_v_i     = 1'b0;
        req_resp_yumi_i = '0;
        check("simul_count", outstanding_o, model_cnt);
        @(negedge clk);
        pop_cmd(c);
        check("simul_send_data", io_cmd_o, c);
        io_cmd_yumi_i = 1'b1;
        @(posedge clk);
        #1 io_cmd_yumi_i = 1'b0;
        respond_one();
        respond_one();

        // Backpressure: link withholds yumi for 10 cycles.
        @(negedge clk);
        rand_cmds();
        req_cmd_v_i = '1;
        #1;
        g = pick(model_rr, '1);
        check("bp_ready", req_cmd_ready_o, oh(g));
        model_rr = g;
        exp_q.push_back(oh(g));
        c = req_cmd_i[g];
        model_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_cmd_v", io_cmd_v_o, 1'b1);
            check("bp_cmd_stable", io_cmd_o, c);
            check("bp_ready_low", req_cmd_ready_o, '0);
            check("bp_state", state_o, e_send);
        end
        io_cmd_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        io_cmd_yumi_i = 1'b0;
        req_cmd_v_i   = '0;
        @(negedge clk);
        check("bp_back_idle", state_o, e_idle);
        check("bp_cmd_v_low", io_cmd_v_o, 1'b0);

        // Yumi on a non-head requester is a protocol error.
        t = (exp_q.size() > 0) ? exp_q[0] : '0;
        req_resp_yumi_i = ~t;
        @(posedge clk);
        #1 req_resp_yumi_i = '0;
        check("err_nonhead_yumi", error_o, 1'b1);

        // Asynchronous reset in the middle of a send.
        accept_one_noyumi: begin
            @(negedge clk);
            rand_cmds();
            req_cmd_v_i = 2'b01;
            @(posedge clk);
            #1 req_cmd_v_i = '0;
            @(negedge clk);
            check("pre_rst_cmd_v", io_cmd_v_o, 1'b1);
            #2 reset_n_i = 1'b0;
            #1;
            check("async_rst_cmd_v", io_cmd_v_o, 1'b0);
            check("async_rst_count", outstanding_o, '0);
            check("async_rst_error", error_o, 1'b0);
            check("async_rst_state", state_o, e_idle);
        end
        exp_q.delete();
        cmd_q.delete();
        model_rr  = NREQ - 1;
        model_cnt = 0;
        @(negedge clk) reset_n_i = 1'b1;

        req_cmd_v_i = '1;
        #1;
        check("post_rst_priority", req_cmd_ready_o, oh(pick(model_rr, '1)));
        req_cmd_v_i = '0;

        // Response with an empty tag queue sets a sticky error.
        @(negedge clk);
        io_resp_v_i = 1'b1;
        io_resp_i   = rnd_word();
        #1;
        check("empty_resp_steer", req_resp_v_o, '0);
        @(posedge clk);
        #1 io_resp_v_i = 1'b0;
        check("err_empty_resp", error_o, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", error_o, 1'b1);
        check("err_count_zero", outstanding_o, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
